// File: rtl/bus_timer.sv
// ---------------------------------------------------------------------------
// bus_timer
//   Memory-mapped down-counting timer that sits in one peripheral slot of the
//   peripheral-controller bus. Software programs a reload value and a clock
//   prescaler, then enables the counter in one-shot or auto-reload mode. When
//   the count expires the TIMEOUT flag is set and, if enabled, a level
//   interrupt is raised towards the interrupt controller.
//
// Ports
//   clk      in     1           rising-edge clock for all state
//   rst      in     1           asynchronous reset, active low
//   data     inout  DATA_WIDTH  shared data bus, driven only during reads
//   address  in     4           register select
//   rw       in     1           1 = write, 0 = read
//   ce       in     1           chip enable for this peripheral
//   irq      out    1           timeout interrupt, level, active high
//
// Register map
//   0x0 CTRL      [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN
//   0x1 LOAD      reload value
//   0x2 COUNT     current count
//   0x3 PRESCALE  prescaler compare value
//   0x4 STATUS    [0] TIMEOUT, write 1 to clear
//   other addresses read 0 and ignore writes
// ---------------------------------------------------------------------------
module bus_timer #(
    parameter int DATA_WIDTH     = 32,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic [3:0]            address,
    input  logic                  rw,
    input  logic                  ce,
    output logic                  irq
);

    localparam logic [3:0] ADDR_CTRL     = 4'h0;
    localparam logic [3:0] ADDR_LOAD     = 4'h1;
    localparam logic [3:0] ADDR_COUNT    = 4'h2;
    localparam logic [3:0] ADDR_PRESCALE = 4'h3;
    localparam logic [3:0] ADDR_STATUS   = 4'h4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic                      auto_reload_q, auto_reload_d;
    logic                      irq_en_q, irq_en_d;
    logic [DATA_WIDTH-1:0]     load_q, load_d;
    logic [DATA_WIDTH-1:0]     count_q, count_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic                      timeout_q, timeout_d;

    logic                      wr_en;
    logic                      rd_en;
    logic                      tick;
    logic                      timeout_set;
    logic                      status_clear;
    logic [DATA_WIDTH-1:0]     rd_data;

    assign wr_en = ce & rw;
    assign rd_en = ce & ~rw;

    // The EN bit is not stored separately: the timer is enabled exactly
    // when the FSM is in RUN, so the two can never disagree.
    assign tick = (state_q == RUN) && (presc_cnt_q == prescale_q);

    assign irq = timeout_q & irq_en_q;

    // Register read mux; unmapped addresses and unused bits read as zero.
    always_comb begin
        rd_data = '0;
        case (address)
            ADDR_CTRL:     rd_data = {{(DATA_WIDTH-3){1'b0}}, irq_en_q, auto_reload_q, (state_q == RUN)};
            ADDR_LOAD:     rd_data = load_q;
            ADDR_COUNT:    rd_data = count_q;
            ADDR_PRESCALE: rd_data = {{(DATA_WIDTH-PRESCALE_WIDTH){1'b0}}, prescale_q};
            ADDR_STATUS:   rd_data = {{(DATA_WIDTH-1){1'b0}}, timeout_q};
            default:       rd_data = '0;
        endcase
    end

    assign data = rd_en ? rd_data : 'z;

    // Next-state logic. Counting is evaluated first and bus writes are
    // applied afterwards, so a write to the same register on the same edge
    // overrides the counter's own update (a COUNT write beats a decrement,
    // a CTRL write with EN=0 stops the timer even on a timeout edge).
    // A TIMEOUT being raised beats a simultaneous write-1-to-clear.
    always_comb begin
        state_d       = state_q;
        auto_reload_d = auto_reload_q;
        irq_en_d      = irq_en_q;
        load_d        = load_q;
        count_d       = count_q;
        prescale_d    = prescale_q;
        presc_cnt_d   = presc_cnt_q;
        timeout_set   = 1'b0;
        status_clear  = 1'b0;

        if (state_q == RUN) begin
            if (tick) begin
                presc_cnt_d = '0;
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    timeout_set = 1'b1;
                    if (auto_reload_q) begin
                        count_d = load_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end else begin
                presc_cnt_d = presc_cnt_q + 1'b1;
            end
        end

        if (wr_en) begin
            case (address)
                ADDR_CTRL: begin
                    auto_reload_d = data[1];
                    irq_en_d      = data[2];
                    if (!data[0]) begin
                        state_d = IDLE;
                    end else if (state_q == IDLE) begin
                        // Fresh enable: start a full period from LOAD.
                        state_d     = RUN;
                        count_d     = load_q;
                        presc_cnt_d = '0;
                    end else begin
                        // Already running: only the mode bits change.
                        state_d = RUN;
                    end
                end
                ADDR_LOAD:     load_d       = data;
                ADDR_COUNT:    count_d      = data;
                ADDR_PRESCALE: prescale_d   = data[PRESCALE_WIDTH-1:0];
                ADDR_STATUS:   status_clear = data[0];
                default:       ;
            endcase
        end

        timeout_d = (timeout_q & ~status_clear) | timeout_set;
    end

    // State register; reset clears everything immediately, so irq drops
    // without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
            load_q        <= '0;
            count_q       <= '0;
            prescale_q    <= '0;
            presc_cnt_q   <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            auto_reload_q <= auto_reload_d;
            irq_en_q      <= irq_en_d;
            load_q        <= load_d;
            count_q       <= count_d;
            prescale_q    <= prescale_d;
            presc_cnt_q   <= presc_cnt_d;
            timeout_q     <= timeout_d;
        end
    end

endmodule
